// File: rtl/cache_flush_engine.sv
// ---------------------------------------------------------------------------
// cache_flush_engine
//
// Walks every line of a set-associative cache (or an inclusive, possibly
// wrapping, range of sets) one way at a time. Each line is cleaned (written
// back), flushed (written back and invalidated) or invalidated depending on
// the requested mode. The tag array is probed through ProbeSet/ProbeWay and
// answers one cycle later on ProbeValid/ProbeDirty/ProbeTag. Dirty lines go
// out on a simple req/ack writeback bus.
//
// Optional feature:
//   CACHE_FLUSH_WBCOUNT_EN  when defined, WbCount counts the writebacks of
//                           the current/last operation (saturating). When
//                           undefined, WbCount is tied to zero.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-low
//   Start        begin an operation (sampled only in IDLE)
//   Mode         00 clean, 01 flush, 10 invalidate, 11 range flush
//   StartSet     first set of a range flush (inclusive)
//   EndSet       last set of a range flush (inclusive)
//   Abort        stop the operation early
//   ProbeSet     set under inspection
//   ProbeWay     one-hot way under inspection
//   ProbeValid   line valid, one cycle after the probe
//   ProbeDirty   line dirty, one cycle after the probe
//   ProbeTag     line tag, one cycle after the probe
//   ClearDirty   one-cycle strobe: clear dirty bit at ProbeSet/ProbeWay
//   ClearValid   one-cycle strobe: clear valid bit at ProbeSet/ProbeWay
//   BusReq       writeback request
//   BusAdr       writeback line address {tag, set, offset zeros}
//   BusAck       writeback complete
//   Busy         high whenever the engine is not idle
//   Done         one-cycle completion pulse
//   WbCount      lines written back in the current/last operation
// ---------------------------------------------------------------------------
module cache_flush_engine #(
  parameter int PA_BITS  = 32,
  parameter int NUMLINES = 64,
  parameter int NUMWAYS  = 4,
  parameter int LINELEN  = 512,
  localparam int OFFSETLEN = $clog2(LINELEN / 8),
  localparam int SETLEN    = $clog2(NUMLINES),
  localparam int TAGLEN    = PA_BITS - SETLEN - OFFSETLEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Start,
  input  logic [1:0]          Mode,
  input  logic [SETLEN-1:0]   StartSet,
  input  logic [SETLEN-1:0]   EndSet,
  input  logic                Abort,
  output logic [SETLEN-1:0]   ProbeSet,
  output logic [NUMWAYS-1:0]  ProbeWay,
  input  logic                ProbeValid,
  input  logic                ProbeDirty,
  input  logic [TAGLEN-1:0]   ProbeTag,
  output logic                ClearDirty,
  output logic                ClearValid,
  output logic                BusReq,
  output logic [PA_BITS-1:0]  BusAdr,
  input  logic                BusAck,
  output logic                Busy,
  output logic                Done,
  output logic [15:0]         WbCount
);

  typedef enum logic [2:0] {
    IDLE,
    PROBE,
    CHECK,
    WRITEBACK,
    UPDATE,
    NEXT,
    DONE
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [1:0]           mode_q;
  logic [SETLEN-1:0]    end_set_q;
  logic [SETLEN-1:0]    set_q;
  logic [NUMWAYS-1:0]   way_q;
  logic [TAGLEN-1:0]    tag_q;
  logic                 did_wb;
  logic                 abort_pend;

  logic [SETLEN-1:0]    last_set;
  logic                 last_probe;
  logic [NUMWAYS-1:0]   way_rot;

  // The walk ends at the top set for whole-cache modes, or at the latched
  // range end for a range flush. NUMLINES is a power of two, so the top set
  // is all ones and the set counter wraps naturally.
  assign last_set   = (mode_q == 2'b11) ? end_set_q : {SETLEN{1'b1}};
  assign last_probe = way_q[NUMWAYS-1] && (set_q == last_set);

  // Rotate-left written with shifts so a single-way cache still works
  // (the rotation of a 1-bit vector is itself).
  assign way_rot = (way_q << 1) | (way_q >> (NUMWAYS - 1));

  assign ProbeSet = set_q;
  assign ProbeWay = way_q;
  assign BusAdr   = {tag_q, set_q, {OFFSETLEN{1'b0}}};

  // Next-state and strobe decode. Abort wins over normal progress in every
  // state except WRITEBACK, where the bus transfer must complete first.
  always_comb begin
    state_next = state;
    BusReq     = 1'b0;
    ClearDirty = 1'b0;
    ClearValid = 1'b0;
    Done       = 1'b0;
    Busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (Start) state_next = PROBE;
      end
      PROBE: begin
        state_next = Abort ? DONE : CHECK;
      end
      CHECK: begin
        if (Abort)
          state_next = DONE;
        else if (ProbeValid && ProbeDirty && (mode_q != 2'b10))
          state_next = WRITEBACK;
        else if (ProbeValid && (mode_q != 2'b00))
          state_next = UPDATE;
        else
          state_next = NEXT;
      end
      WRITEBACK: begin
        BusReq = 1'b1;
        if (BusAck) state_next = UPDATE;
      end
      UPDATE: begin
        ClearDirty = did_wb;
        ClearValid = (mode_q != 2'b00);
        state_next = (Abort || abort_pend) ? DONE : NEXT;
      end
      NEXT: begin
        state_next = (Abort || last_probe) ? DONE : PROBE;
      end
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and walk datapath. The probe position only moves when
  // another probe follows, so after completion it still names the last
  // line that was inspected.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      mode_q     <= 2'b00;
      end_set_q  <= '0;
      set_q      <= '0;
      way_q      <= NUMWAYS'(1);
      tag_q      <= '0;
      did_wb     <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (Start) begin
            mode_q     <= Mode;
            end_set_q  <= EndSet;
            set_q      <= (Mode == 2'b11) ? StartSet : '0;
            way_q      <= NUMWAYS'(1);
            did_wb     <= 1'b0;
            abort_pend <= 1'b0;
          end
        end
        CHECK: begin
          tag_q  <= ProbeTag;
          did_wb <= (state_next == WRITEBACK);
        end
        WRITEBACK: begin
          if (Abort) abort_pend <= 1'b1;
        end
        NEXT: begin
          if (state_next == PROBE) begin
            way_q <= way_rot;
            if (way_q[NUMWAYS-1]) set_q <= set_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CACHE_FLUSH_WBCOUNT_EN
  logic [15:0] wb_count;

  // Cleared when a new operation is accepted; saturates rather than wraps.
  always_ff @(posedge clk) begin
    if (!reset)
      wb_count <= 16'h0000;
    else if ((state == IDLE) && Start)
      wb_count <= 16'h0000;
    else if ((state == WRITEBACK) && BusAck && (wb_count != 16'hFFFF))
      wb_count <= wb_count + 16'h0001;
  end

  assign WbCount = wb_count;
`else
  assign WbCount = 16'h0000;
`endif

endmodule
